// File: rtl/subterranean_axi_pkg.sv
// subterranean_axi_pkg: opcodes, AXI response codes, FSM encoding and strobe helper
// shared by the Subterranean AXI4-Lite initiator.
package subterranean_axi_pkg;

    localparam logic [2:0] OP_INIT     = 3'b000;
    localparam logic [2:0] OP_DUPLEX   = 3'b001;
    localparam logic [2:0] OP_ENCRYPT  = 3'b010;
    localparam logic [2:0] OP_DECRYPT  = 3'b011;
    localparam logic [2:0] OP_SQUEEZE  = 3'b100;
    localparam logic [2:0] OP_READ_BUF = 3'b101;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RESP    = 3'd5
    } state_t;

    // Sizes of 4 and above all mean a full word.
    function automatic logic [3:0] size_to_wstrb(input logic [2:0] size);
        return size == 3'd0 ? 4'b0000 :
               size == 3'd1 ? 4'b0001 :
               size == 3'd2 ? 4'b0011 :
               size == 3'd3 ? 4'b0111 : 4'b1111;
    endfunction

endpackage

// File: rtl/subterranean_axi4_lite_master.sv
// subterranean_axi4_lite_master: turns valid/ready cipher commands into single AXI4-Lite
// writes or reads, with a per-phase timeout, and returns status on a response port.
module subterranean_axi4_lite_master
    import subterranean_axi_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [2:0]        cmd_op,
    input  logic [2:0]        cmd_size,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmd_ready_d, rsp_valid_d, rsp_timeout_d;
    logic [31:0]        rsp_rdata_d, wdata_d;
    logic [1:0]         rsp_resp_d;
    logic [ADDR_W-1:0]  awaddr_d, araddr_d, cmd_addr;
    logic [3:0]         wstrb_d;
    logic               awvalid_d, wvalid_d, arvalid_d, bready_d, rready_d;
    logic               stall, abort, expired;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign cmd_addr     = ADDR_W'({cmd_op, cmd_size, 2'b00});
    assign expired      = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        stall         = 1'b0;
        abort         = 1'b0;
        awvalid_d     = m_axi_awvalid;
        wvalid_d      = m_axi_wvalid;
        arvalid_d     = m_axi_arvalid;
        bready_d      = m_axi_bready;
        rready_d      = m_axi_rready;
        awaddr_d      = m_axi_awaddr;
        araddr_d      = m_axi_araddr;
        wdata_d       = m_axi_wdata;
        wstrb_d       = m_axi_wstrb;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_resp_d    = rsp_resp;
        rsp_timeout_d = rsp_timeout;
        case (state_q)
            ST_IDLE: if (cmd_valid && cmd_ready) begin
                if (cmd_write) begin
                    state_d   = ST_WR_REQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = size_to_wstrb(cmd_size);
                end else begin
                    state_d   = ST_RD_REQ;
                    arvalid_d = 1'b1;
                    araddr_d  = cmd_addr;
                end
            end
            ST_WR_REQ: begin
                awvalid_d = m_axi_awvalid && !m_axi_awready;
                wvalid_d  = m_axi_wvalid && !m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = ST_WR_RESP;
                    bready_d = 1'b1;
                end else begin
                    // a partial handshake restarts the wait window
                    stall = !(m_axi_awvalid && m_axi_awready) && !(m_axi_wvalid && m_axi_wready);
                end
            end
            ST_WR_RESP: if (m_axi_bvalid) begin
                state_d       = ST_RESP;
                bready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = '0;
                rsp_resp_d    = m_axi_bresp;
                rsp_timeout_d = 1'b0;
            end else begin
                stall = 1'b1;
            end
            ST_RD_REQ: if (m_axi_arready) begin
                state_d   = ST_RD_RESP;
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end else begin
                stall = 1'b1;
            end
            ST_RD_RESP: if (m_axi_rvalid) begin
                state_d       = ST_RESP;
                rready_d      = 1'b0;
                rsp_valid_d   = 1'b1;
                rsp_rdata_d   = m_axi_rdata;
                rsp_resp_d    = m_axi_rresp;
                rsp_timeout_d = 1'b0;
            end else begin
                stall = 1'b1;
            end
            ST_RESP: if (rsp_ready) begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (stall) begin
            abort = expired;
            cnt_d = expired ? '0 : cnt_q + CNT_W'(1);
        end
        if (abort) begin
            state_d       = ST_RESP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_resp_d    = RESP_SLVERR;
            rsp_timeout_d = 1'b1;
        end
        cmd_ready_d = state_d == ST_IDLE;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            rsp_timeout   <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready     <= cmd_ready_d;
            rsp_valid     <= rsp_valid_d;
            rsp_rdata     <= rsp_rdata_d;
            rsp_resp      <= rsp_resp_d;
            rsp_timeout   <= rsp_timeout_d;
            m_axi_awaddr  <= awaddr_d;
            m_axi_awvalid <= awvalid_d;
            m_axi_wdata   <= wdata_d;
            m_axi_wstrb   <= wstrb_d;
            m_axi_wvalid  <= wvalid_d;
            m_axi_bready  <= bready_d;
            m_axi_araddr  <= araddr_d;
            m_axi_arvalid <= arvalid_d;
            m_axi_rready  <= rready_d;
        end
    end

endmodule

// File: tb/tb_subterranean_axi4_lite_master.sv
// tb_subterranean_axi4_lite_master: scenario tasks driving a scripted AXI4-Lite slave,
// with expected responses queued at command time and compared when rsp_valid appears.
module tb_subterranean_axi4_lite_master;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [2:0]  cmd_op = '0, cmd_size = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;

    always #5 aclk = ~aclk;

    subterranean_axi4_lite_master #(.ADDR_W(8), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_op(cmd_op), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    // One transaction against a slave whose ready/response timing is set by the arguments.
    task automatic run_txn(input logic wr, input logic [2:0] op, input logic [2:0] sz,
                           input logic [31:0] wd, input logic [7:0] exp_addr, input logic [3:0] exp_strb,
                           input int req_dly, input int w_dly, input int rsp_dly,
                           input logic [31:0] rd, input logic [1:0] rs, input bit no_resp,
                           output int t_done, output int t_rsp);
        exp_t e, got;
        int aw_hs, w_hs, b_hs, ar_hs, r_hs, t;
        bit aw_p, w_p, b_p, ar_p, r_p, bad_hold;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(posedge aclk); #1; t++;
        end
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_wait: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1; cmd_write = wr; cmd_op = op; cmd_size = sz; cmd_wdata = wd;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        e.rdata = (wr || no_resp) ? 32'h0 : rd;
        e.resp  = no_resp ? 2'b10 : rs;
        e.tmo   = no_resp;
        sb.push_back(e);
        n_chk++;
        if (wr ? ({awvalid, wvalid, arvalid, awaddr, wstrb, wdata} !== {3'b110, exp_addr, exp_strb, wd})
               : ({awvalid, wvalid, arvalid, araddr} !== {3'b001, exp_addr}))
            $display("FAIL request_issue: aw/w/ar valid=%b%b%b awaddr=%h araddr=%h wstrb=%b wdata=%h required addr=%h strb=%b data=%h",
                     awvalid, wvalid, arvalid, awaddr, araddr, wstrb, wdata, exp_addr, exp_strb, wd);
        else n_pass++;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs} = '0;
        {aw_p, w_p, b_p, ar_p, r_p, bad_hold} = '0;
        t_done = -1;
        t_rsp = -1;
        for (t = 0; t < 80; t++) begin
            aw_hs += int'(aw_p); w_hs += int'(w_p); b_hs += int'(b_p);
            ar_hs += int'(ar_p); r_hs += int'(r_p);
            if (rsp_valid === 1'b1) begin
                t_rsp = t;
                break;
            end
            if (wr) begin
                if ((w_hs > 0 && wvalid) || (aw_hs > 0 && awvalid)) bad_hold = 1'b1;
                if ((w_hs == 0 && !wvalid) || (aw_hs == 0 && !awvalid)) bad_hold = 1'b1;
                if (awvalid && awaddr !== exp_addr) bad_hold = 1'b1;
                if (wvalid && (wdata !== wd || wstrb !== exp_strb)) bad_hold = 1'b1;
                if (t_done < 0 && aw_hs > 0 && w_hs > 0) t_done = t;
            end else begin
                if ((ar_hs > 0 && arvalid) || (ar_hs == 0 && !arvalid)) bad_hold = 1'b1;
                if (arvalid && araddr !== exp_addr) bad_hold = 1'b1;
                if (t_done < 0 && ar_hs > 0) t_done = t;
            end
            awready = wr && t >= req_dly;
            wready  = wr && t >= w_dly;
            arready = !wr && t >= req_dly;
            bvalid  = wr && !no_resp && t_done >= 0 && t - t_done >= rsp_dly && b_hs == 0;
            bresp   = rs;
            rvalid  = !wr && !no_resp && t_done >= 0 && t - t_done >= rsp_dly && r_hs == 0;
            rdata   = rvalid ? rd : 32'hx;
            rresp   = rs;
            aw_p = awvalid && awready; w_p = wvalid && wready; b_p = bvalid && bready;
            ar_p = arvalid && arready; r_p = rvalid && rready;
            @(posedge aclk); #1;
        end
        {awready, wready, arready, bvalid, rvalid} = '0;
        n_chk++;
        if (t_rsp < 0) $display("FAIL rsp_wait: rsp_valid=%b after 80 cycles required 1", rsp_valid);
        else n_pass++;
        got = e;
        if (sb.size() > 0) got = sb.pop_front();
        n_chk++;
        if ({rsp_rdata, rsp_resp, rsp_timeout} !== {got.rdata, got.resp, got.tmo})
            $display("FAIL rsp_fields: rdata=%h resp=%b timeout=%b required rdata=%h resp=%b timeout=%b",
                     rsp_rdata, rsp_resp, rsp_timeout, got.rdata, got.resp, got.tmo);
        else n_pass++;
        n_chk++;
        if (wr ? ({aw_hs, w_hs, b_hs} !== {32'd1, 32'd1, no_resp ? 32'd0 : 32'd1})
               : ({ar_hs, r_hs} !== {32'd1, no_resp ? 32'd0 : 32'd1}))
            $display("FAIL handshake_count: aw=%0d w=%0d b=%0d ar=%0d r=%0d required one per channel used",
                     aw_hs, w_hs, b_hs, ar_hs, r_hs);
        else n_pass++;
        n_chk++;
        if (bad_hold || {awvalid, wvalid, arvalid, bready, rready, cmd_ready} !== 6'b0)
            $display("FAIL channel_hold: bad_hold=%b valids/readies/cmd_ready=%b%b%b%b%b%b required 0",
                     bad_hold, awvalid, wvalid, arvalid, bready, rready, cmd_ready);
        else n_pass++;
        @(posedge aclk); #1;
        n_chk++;
        if ({rsp_valid, rsp_rdata, rsp_resp, rsp_timeout} !== {1'b1, got.rdata, got.resp, got.tmo})
            $display("FAIL rsp_stable: valid=%b rdata=%h resp=%b timeout=%b required held", rsp_valid,
                     rsp_rdata, rsp_resp, rsp_timeout);
        else n_pass++;
        rsp_ready = 1'b1;
        @(posedge aclk); #1;
        rsp_ready = 1'b0;
        n_chk++;
        if ({rsp_valid, cmd_ready} !== 2'b01)
            $display("FAIL rsp_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
        else n_pass++;
    endtask

    task automatic test_reset;
        aresetn = 1'b0;
        #1;
        n_chk++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, awaddr, awprot, awvalid, wdata, wstrb,
             wvalid, bready, araddr, arprot, arvalid, rready} !== '0)
            $display("FAIL reset_outputs: some output nonzero cmd_ready=%b rsp_valid=%b awaddr=%h wstrb=%b",
                     cmd_ready, rsp_valid, awaddr, wstrb);
        else n_pass++;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        n_chk++;
        if (cmd_ready !== 1'b1) $display("FAIL idle_ready: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_init;
        int td, tr;
        run_txn(1'b1, 3'b000, 3'd4, 32'h0000_0000, 8'h10, 4'b1111, 0, 0, 0, 32'h0, 2'b00, 1'b0, td, tr);
    endtask

    task automatic test_encrypt_w_first;
        int td, tr;
        run_txn(1'b1, 3'b010, 3'd2, 32'hDEAD_BEEF, 8'h48, 4'b0011, 3, 0, 1, 32'h0, 2'b00, 1'b0, td, tr);
        n_chk++;
        if (td !== 4) $display("FAIL encrypt_aw_late: both handshakes done at t=%0d required 4", td);
        else n_pass++;
    endtask

    task automatic test_read_buffer;
        int td, tr;
        run_txn(1'b0, 3'b101, 3'd0, 32'h0, 8'hA0, 4'b0000, 0, 0, 5, 32'h1234_5678, 2'b00, 1'b0, td, tr);
    endtask

    task automatic test_read_slverr;
        int td, tr;
        run_txn(1'b0, 3'b110, 3'd0, 32'h0, 8'hC0, 4'b0000, 1, 0, 2, 32'hBAD0_0001, 2'b10, 1'b0, td, tr);
    endtask

    task automatic test_strobe_sweep;
        logic [3:0] strb_tab [8];
        int td, tr;
        strb_tab = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF};
        for (int s = 0; s < 8; s++)
            run_txn(1'b1, 3'b001, 3'(s), $urandom, 8'h20 | 8'(s << 2), strb_tab[s],
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    32'h0, s[0] ? 2'b10 : 2'b00, 1'b0, td, tr);
    endtask

    task automatic test_timeout;
        int td, tr;
        run_txn(1'b1, 3'b011, 3'd7, 32'hCAFE_F00D, 8'h7C, 4'b1111, 0, 0, 0, 32'h0, 2'b00, 1'b1, td, tr);
        n_chk++;
        if (tr - td !== 16) $display("FAIL timeout_latency: %0d cycles after handshakes required 16", tr - td);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read;
        int td, tr;
        bit seen;
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) begin
            @(posedge aclk); #1;
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_op = 3'b101; cmd_size = 3'd1;
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
        arready = 1'b1;
        @(posedge aclk); #1;
        arready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        n_chk++;
        if (rready !== 1'b1) $display("FAIL rd_resp_entry: rready=%b required 1", rready);
        else n_pass++;
        #2 aresetn = 1'b0;
        #1;
        n_chk++;
        if ({cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, awaddr, awprot, awvalid, wdata, wstrb,
             wvalid, bready, araddr, arprot, arvalid, rready} !== '0)
            $display("FAIL async_reset: outputs nonzero rready=%b araddr=%h cmd_ready=%b", rready, araddr, cmd_ready);
        else n_pass++;
        @(posedge aclk);
        #1 aresetn = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(posedge aclk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_chk++;
        if (seen) $display("FAIL aborted_rsp: rsp_valid=1 seen required 0");
        else n_pass++;
        run_txn(1'b0, 3'b100, 3'd3, 32'h0, 8'h8C, 4'b0000, 0, 0, 0, 32'h0BAD_CAFE, 2'b00, 1'b0, td, tr);
    endtask

    initial begin
        test_reset();
        test_write_init();
        test_encrypt_w_first();
        test_read_buffer();
        test_read_slverr();
        test_strobe_sweep();
        test_timeout();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
